wdt_service: RTL and testbench

Bus-side service controller for the watchdog timer. It holds the watchdog configuration: enable, the three prescale select bits and a lock bit. Software kicks the watchdog with a two-word key sequence, and this block checks that each kick respects a minimum service window before it issues the kick pulse on the watchdog's `watchdog_rst` input. It also captures watchdog timeouts (`pc_rst`) and service violations into sticky status bits for software.

---
 rtl/wdt_service_pkg.sv | 21 ++
 rtl/wdt_service_pulse_sync.sv | 28 ++
 rtl/wdt_service.sv | 140 ++++++++++++++
 tb/tb_wdt_service.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wdt_service_pkg.sv
// Shared definitions for the watchdog service controller: register map,
// STATUS bit positions and key-sequence FSM encoding.
package wdt_service_pkg;

   localparam logic [1:0] WDT_CTRL   = 2'd0;
   localparam logic [1:0] WDT_KEY    = 2'd1;
   localparam logic [1:0] WDT_STATUS = 2'd2;
   localparam logic [1:0] WDT_SINCE  = 2'd3;

   localparam int ST_TIMEOUT = 0;
   localparam int ST_KEY_ERR = 1;
   localparam int ST_WIN_ERR = 2;
   localparam int ST_LOCK    = 3;
   localparam int ST_ARMED   = 4;

   typedef enum logic {
      KEY_IDLE  = 1'b0,
      KEY_ARMED = 1'b1
   } key_state_e;

endpackage

// File: rtl/wdt_service_pulse_sync.sv
// Two-flop synchronizer with rising-edge detect for an asynchronous level.
// rise_o is a one-cycle pulse two clk edges after the input is first sampled high.
module pulse_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic sig_i,
   output logic rise_o
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= sig_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/wdt_service.sv
// Watchdog service controller: config register, two-word key kick with minimum
// service window, kick/violation pulses and sticky status. No backpressure; rdata one cycle after rd_en.
module wdt_service
   import wdt_service_pkg::*;
#(
   parameter int          WIN_MIN = 256,
   parameter int          KICK_W  = 2,
   parameter logic [15:0] KEY1    = 16'h5A5A,
   parameter logic [15:0] KEY2    = 16'hA5A5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [1:0]  addr,
   input  logic [15:0] wdata,
   output logic [15:0] rdata,
   input  logic        pc_rst,
   output logic        wd_en,
   output logic        prescale_0,
   output logic        prescale_1,
   output logic        prescale_2,
   output logic        watchdog_rst,
   output logic        viol_rst
);

   key_state_e  state_q, state_d;
   logic [3:0]  ctrl_q, ctrl_d;
   logic        lock_q, lock_d;
   logic [15:0] since_q, since_d;
   logic [15:0] kick_cnt_q, kick_cnt_d;
   logic [2:0]  status_q, status_d;
   logic [15:0] rdata_q, rdata_d;
   logic        viol_q, viol_d;

   logic wr_ctrl, wr_key, wr_status;
   logic key_err, kick_done, in_window, kick_ok, win_err, to_rise;
   logic [2:0] clr_mask;

   pulse_sync u_pc_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .sig_i  (pc_rst),
      .rise_o (to_rise)
   );

   assign wr_ctrl   = wr_en && (addr == WDT_CTRL);
   assign wr_key    = wr_en && (addr == WDT_KEY);
   assign wr_status = wr_en && (addr == WDT_STATUS);

   always_comb begin
      state_d   = state_q;
      key_err   = 1'b0;
      kick_done = 1'b0;
      if (wr_key) begin
         case (state_q)
            KEY_IDLE: begin
               if (wdata == KEY1) state_d = KEY_ARMED;
               else               key_err = 1'b1;
            end
            KEY_ARMED: begin
               state_d = KEY_IDLE;
               if (wdata == KEY2) kick_done = 1'b1;
               else               key_err   = 1'b1;
            end
            default: state_d = KEY_IDLE;
         endcase
      end
   end

   // With the watchdog disabled a completed sequence is silently dropped.
   assign in_window = (since_q >= 16'(WIN_MIN));
   assign kick_ok   = kick_done && ctrl_q[0] && in_window;
   assign win_err   = kick_done && ctrl_q[0] && !in_window;

   always_comb begin
      ctrl_d = ctrl_q;
      lock_d = lock_q;
      if (wr_ctrl && !lock_q) begin
         ctrl_d = wdata[3:0];
         lock_d = wdata[4];
      end

      since_d = since_q;
      if (kick_ok)                 since_d = 16'h0000;
      else if (since_q != 16'hFFFF) since_d = since_q + 16'd1;

      kick_cnt_d = kick_cnt_q;
      if (kick_ok)                   kick_cnt_d = 16'(KICK_W);
      else if (kick_cnt_q != 16'd0)  kick_cnt_d = kick_cnt_q - 16'd1;

      // New events are ORed in after the clear so a coincident set survives.
      clr_mask = wr_status ? wdata[2:0] : 3'b000;
      status_d = (status_q & ~clr_mask) | {win_err, key_err, to_rise};

      viol_d = key_err | win_err;

      rdata_d = rdata_q;
      if (rd_en) begin
         case (addr)
            WDT_CTRL:   rdata_d = {11'b0, lock_q, ctrl_q};
            WDT_KEY:    rdata_d = 16'h0000;
            WDT_STATUS: rdata_d = {11'b0, (state_q == KEY_ARMED), lock_q, status_q};
            WDT_SINCE:  rdata_d = since_q;
            default:    rdata_d = 16'h0000;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= KEY_IDLE;
         ctrl_q     <= 4'h0;
         lock_q     <= 1'b0;
         since_q    <= 16'hFFFF;
         kick_cnt_q <= 16'h0000;
         status_q   <= 3'b000;
         rdata_q    <= 16'h0000;
         viol_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ctrl_q     <= ctrl_d;
         lock_q     <= lock_d;
         since_q    <= since_d;
         kick_cnt_q <= kick_cnt_d;
         status_q   <= status_d;
         rdata_q    <= rdata_d;
         viol_q     <= viol_d;
      end
   end

   assign rdata        = rdata_q;
   assign wd_en        = ctrl_q[0];
   assign prescale_0   = ctrl_q[1];
   assign prescale_1   = ctrl_q[2];
   assign prescale_2   = ctrl_q[3];
   assign watchdog_rst = (kick_cnt_q != 16'h0000);
   assign viol_rst     = viol_q;

endmodule

// File: tb/tb_wdt_service.sv
// Bench for wdt_service: directed scenarios then random register traffic,
// checked every cycle against a timestamp-based model of the register behaviour.
module tb_wdt_service;

   localparam int          WIN_MIN = 256;
   localparam int          KICK_W  = 2;
   localparam logic [15:0] KEY1    = 16'h5A5A;
   localparam logic [15:0] KEY2    = 16'hA5A5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_en = 1'b0;
   logic        rd_en = 1'b0;
   logic [1:0]  addr = 2'd0;
   logic [15:0] wdata = 16'h0;
   logic [15:0] rdata;
   logic        pc_rst = 1'b0;
   logic        wd_en, prescale_0, prescale_1, prescale_2, watchdog_rst, viol_rst;

   wdt_service #(.WIN_MIN(WIN_MIN), .KICK_W(KICK_W), .KEY1(KEY1), .KEY2(KEY2)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
      .wdata(wdata), .rdata(rdata), .pc_rst(pc_rst), .wd_en(wd_en),
      .prescale_0(prescale_0), .prescale_1(prescale_1), .prescale_2(prescale_2),
      .watchdog_rst(watchdog_rst), .viol_rst(viol_rst)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Model state: edge counter n, timestamps of the last accepted kick and violation.
   int          n = 0;
   int          rst_edge = 0;
   bit          hist [int];
   bit          pc_lvl = 1'b0;
   bit          m_kicked = 1'b0;
   int          m_k = 0;
   int          m_viol = -10;
   bit          m_armed = 1'b0;
   bit          m_lock = 1'b0;
   logic [3:0]  m_ctrl = 4'h0;
   logic [2:0]  m_st = 3'b000;
   logic [15:0] m_rdata = 16'h0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @edge %0d: got %0h expected %0h", tag, n, got, exp);
      end
   endtask

   function automatic int since_at(input int m);
      if (!m_kicked) return 65535;
      return (m - m_k > 65535) ? 65535 : (m - m_k);
   endfunction

   function automatic bit pc_at(input int m);
      if (m <= rst_edge) return 1'b0;
      if (!hist.exists(m)) return 1'b0;
      return hist[m];
   endfunction

   task automatic do_cycle(input bit we, input bit re, input logic [1:0] a, input logic [15:0] d);
      logic [2:0] clr;
      bit key_e, win_e, to_e, old_wd;
      wr_en = we; rd_en = re; addr = a; wdata = d; pc_rst = pc_lvl;
      @(posedge clk);
      n++;
      hist[n] = pc_lvl;
      if (re) begin
         case (a)
            2'd0: m_rdata = {11'b0, m_lock, m_ctrl};
            2'd1: m_rdata = 16'h0;
            2'd2: m_rdata = {11'b0, m_armed, m_lock, m_st};
            default: m_rdata = 16'(since_at(n - 1));
         endcase
      end
      key_e = 0; win_e = 0; clr = 3'b000; old_wd = m_ctrl[0];
      if (we) begin
         case (a)
            2'd0: if (!m_lock) begin m_ctrl = d[3:0]; m_lock = d[4]; end
            2'd1: begin
               if (!m_armed) begin
                  if (d == KEY1) m_armed = 1; else key_e = 1;
               end else begin
                  m_armed = 0;
                  if (d != KEY2) key_e = 1;
                  else if (old_wd) begin
                     if (since_at(n - 1) >= WIN_MIN) begin m_kicked = 1; m_k = n; end
                     else win_e = 1;
                  end
               end
            end
            2'd2: clr = d[2:0];
            default: ;
         endcase
      end
      to_e = pc_at(n - 2) && !pc_at(n - 3);
      m_st = (m_st & ~clr) | {win_e, key_e, to_e};
      if (key_e || win_e) m_viol = n;
      #1;
      wr_en = 0; rd_en = 0;
      check_val("watchdog_rst", watchdog_rst, (m_kicked && (n - m_k < KICK_W)));
      check_val("viol_rst", viol_rst, (m_viol == n));
      check_val("ctrl_out", {prescale_2, prescale_1, prescale_0, wd_en}, m_ctrl);
      check_val("rdata", rdata, m_rdata);
   endtask

   task automatic wr(input logic [1:0] a, input logic [15:0] d);
      do_cycle(1, 0, a, d);
   endtask

   task automatic rd(input logic [1:0] a);
      do_cycle(0, 1, a, 16'h0);
   endtask

   task automatic idle(input int cnt);
      for (int i = 0; i < cnt; i++) do_cycle(0, 0, 2'd0, 16'h0);
   endtask

   task automatic do_reset();
      wr_en = 0; rd_en = 0; pc_lvl = 0; pc_rst = 0;
      rst_n = 0;
      #1;
      check_val("rst_watchdog_rst", watchdog_rst, 0);
      check_val("rst_viol_rst", viol_rst, 0);
      check_val("rst_wd_en", wd_en, 0);
      check_val("rst_rdata", rdata, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      rst_edge = n;
      m_kicked = 0; m_viol = -10; m_armed = 0; m_lock = 0;
      m_ctrl = 4'h0; m_st = 3'b000; m_rdata = 16'h0;
   endtask

   initial begin
      int r;
      logic [15:0] d;
      #2;
      do_reset();

      // Reset values of every register.
      rd(2'd0); check_val("reset_ctrl", rdata, 16'h0000);
      rd(2'd1);
      rd(2'd2); check_val("reset_status", rdata, 16'h0000);
      rd(2'd3); check_val("reset_since", rdata, 16'hFFFF);

      // Accepted kick after a long wait.
      wr(2'd0, 16'h0003);
      idle(300);
      wr(2'd1, KEY1);
      wr(2'd1, KEY2);
      check_val("kick_first_cycle", watchdog_rst, 1);
      idle(2);
      rd(2'd3);

      // Second kick too early: window error.
      idle(50);
      wr(2'd1, KEY1);
      wr(2'd1, KEY2);
      idle(1);
      rd(2'd2); check_val("win_err_status", rdata, 16'h0004);

      // Bad second key word.
      wr(2'd2, 16'h0007);
      wr(2'd1, KEY1);
      wr(2'd1, 16'h1234);
      rd(2'd2); check_val("key_err_status", rdata, 16'h0002);
      wr(2'd2, 16'h0002);
      rd(2'd2); check_val("key_err_cleared", rdata, 16'h0000);

      // Lock holds CTRL until reset.
      wr(2'd0, 16'h0011);
      wr(2'd0, 16'h0000);
      rd(2'd0); check_val("locked_ctrl", rdata, 16'h0011);
      do_reset();
      rd(2'd0); check_val("ctrl_after_reset", rdata, 16'h0000);

      // Timeout capture and set-beats-clear.
      pc_lvl = 1; idle(4); pc_lvl = 0; idle(1);
      rd(2'd2); check_val("timeout_seen", rdata, 16'h0001);
      idle(3);
      pc_lvl = 1; idle(2);
      wr(2'd2, 16'h0001);
      pc_lvl = 0;
      rd(2'd2); check_val("set_beats_w1c", rdata, 16'h0001);
      wr(2'd2, 16'h0001);

      // Key sequence with the watchdog disabled.
      idle(300);
      wr(2'd1, KEY1);
      wr(2'd1, KEY2);
      rd(2'd2); check_val("disabled_kick_status", rdata, 16'h0000);

      // Reset during an active pulse.
      wr(2'd0, 16'h0001);
      wr(2'd1, KEY1);
      wr(2'd1, KEY2);
      do_reset();

      // Random traffic.
      for (int it = 0; it < 300; it++) begin
         r = $urandom_range(0, 99);
         if (r < 15) begin
            wr(2'd1, ($urandom_range(0, 9) == 0) ? 16'($urandom) : KEY1);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            wr(2'd1, ($urandom_range(0, 9) == 0) ? 16'($urandom) : KEY2);
         end else if (r < 30) begin
            idle($urandom_range(1, 320));
         end else if (r < 45) begin
            d = 16'($urandom) & 16'h000E;
            if ($urandom_range(0, 9) < 7) d[0] = 1'b1;
            if ($urandom_range(0, 9) == 0) d[4] = 1'b1;
            wr(2'd0, d);
         end else if (r < 60) begin
            rd(2'($urandom_range(0, 3)));
         end else if (r < 70) begin
            wr(2'd2, 16'($urandom_range(0, 7)));
         end else if (r < 80) begin
            case ($urandom_range(0, 2))
               0: d = KEY1;
               1: d = KEY2;
               default: d = 16'($urandom);
            endcase
            wr(2'd1, d);
         end else if (r < 92) begin
            pc_lvl = ~pc_lvl;
            idle($urandom_range(1, 5));
         end else if (r < 97) begin
            wr(2'($urandom_range(0, 3)), 16'($urandom));
         end else begin
            do_reset();
         end
      end
      rd(2'd2);
      rd(2'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
